uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATAWIDTH, default 8, number of data bits per frame.
REQ-002 Parameter OVERSAMPLE, default 16, number of baud_tick pulses per serial bit.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low: flops reset on a rising clk edge while rst=0.
REQ-005 baud_tick  input  1  one-clk enable pulse at OVERSAMPLE x baud rate; bit timing advances only on ticks.
REQ-006 tx_start  input  1  request to send; sampled only while tx_busy=0.
REQ-007 tx_data  input  DATAWIDTH  word to send; captured in the cycle tx_start is accepted.
REQ-008 serial_out  output  1  registered line output; idle high.
REQ-009 tx_busy  output  1  high from the cycle after acceptance until the frame completes.
REQ-010 tx_done  output  1  one-clk pulse marking frame completion.

Function
REQ-011 Frame SHALL be 1 start bit (0), DATAWIDTH data bits LSB first, 1 stop bit (1); no parity.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE: serial_out=1, tx_busy=0; tx_start=1 moves to START, loads tx_data into the shift register, and clears the tick and bit counters.
REQ-014 Acceptance SHALL NOT depend on baud_tick: tx_start at edge N gives serial_out=0 and tx_busy=1 after edge N+1.
REQ-015 tx_start while tx_busy=1 SHALL be ignored; the captured word is unaffected by later tx_data changes.
REQ-016 The tick counter (0..OVERSAMPLE-1) SHALL increment only on baud_tick; a bit ends on the tick where count=OVERSAMPLE-1, and the counter wraps to 0.
REQ-017 START: at bit end go to DATA and drive data bit 0.
REQ-018 DATA: at each bit end shift right one place and increment the bit counter; after bit DATAWIDTH-1 ends, go to STOP with serial_out=1.
REQ-019 STOP: at bit end go to IDLE; tx_done=1 and tx_busy=0 for exactly the next clk cycle.
REQ-020 Every bit SHALL last exactly OVERSAMPLE baud_tick pulses; a frame lasts (DATAWIDTH+2)*OVERSAMPLE ticks.
REQ-021 tx_start asserted in the tx_done cycle SHALL be accepted, giving back-to-back frames with no extra idle bit.
REQ-022 serial_out SHALL be driven from a flop and SHALL be glitch-free.
REQ-023 baud_tick held at 0 SHALL freeze the FSM, counters and serial_out.

Reset
REQ-024 rst=0 SHALL force state=IDLE, serial_out=1, tx_busy=0, tx_done=0, and the counters and shift register to 0.
REQ-025 rst=0 mid-frame SHALL abort the frame: serial_out=1 from the next edge, and no tx_done pulse.
REQ-026 After rst rises, tx_start SHALL be accepted in the first cycle.

Structure
REQ-027 Package uart_pkg SHALL hold the DATAWIDTH/OVERSAMPLE defaults and the tx state enum shared with the receiver side.
REQ-028 Sub-module tx_piso_reg (parallel-load, serial-out shift register, LSB out) SHALL hold the data word; uart_tx holds the FSM and counters.
REQ-029 Counter widths SHALL be $clog2 of their range; no latches and no combinational path from input to serial_out.

Verification
REQ-030 OVERSAMPLE=4, tick every clk, tx_data=8'hA5 -> serial_out 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles; tx_done after 40 ticks.
REQ-031 tx_data=8'h00 then 8'hFF, with tx_start held high -> two contiguous frames; second start bit begins in the first frame's tx_done cycle.
REQ-032 tx_start pulsed again mid-frame with 8'h3C -> ignored; the original word completes and one tx_done is seen.
REQ-033 rst=0 during data bit 3 of 8'h5A -> serial_out=1 and tx_busy=0 next edge, no tx_done; a new tx_start afterwards sends a clean frame.
REQ-034 baud_tick every 3rd clk, OVERSAMPLE=16 -> each bit lasts 48 clk, frame 480 clk; a scoreboard decodes the bytes correctly.
REQ-035 Loopback serial_out into the receiver datapath with random bytes -> RX_DATA matches every transmitted byte.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART transmitter and receiver side.
//   UART_DATAWIDTH  : default number of data bits per frame
//   UART_OVERSAMPLE : default number of baud_tick pulses per serial bit
//   tx_state_t      : transmitter FSM state encoding
//   cnt_width()     : counter width for a 0..range_n-1 counter (never below 1)
package uart_pkg;

  localparam int UART_DATAWIDTH  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // $clog2(1) is 0, which would give a zero-width counter; clamp to one bit.
  function automatic int cnt_width(input int range_n);
    return (range_n > 1) ? $clog2(range_n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_piso.sv
// tx_piso_reg -- parallel-load, serial-out shift register, LSB out first.
//   clk       : clock, rising edge
//   rst       : synchronous active-low reset, clears the register
//   load      : capture load_data (takes priority over shift)
//   load_data : parallel word to capture
//   shift     : shift right one place, zero fills from the top
//   lsb       : current least significant bit (next bit to send)
module tx_piso_reg
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_DATAWIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic             lsb
);

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic upper;
      // The top bit has no neighbour above it and fills with zero.
      if (gi == WIDTH - 1) begin : g_top
        assign upper = 1'b0;
      end else begin : g_mid
        assign upper = shift_reg[gi+1];
      end
      assign shift_next[gi] = load  ? load_data[gi] :
                              shift ? upper         : shift_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_reg <= '0;
    end else begin
      shift_reg <= shift_next;
    end
  end

  assign lsb = shift_reg[0];

endmodule

// File: rtl/uart_tx.sv
// uart_tx -- UART transmitter: 1 start bit, DATAWIDTH data bits LSB first,
// 1 stop bit, no parity. Bit timing advances only on baud_tick.
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset; aborts any frame in flight
//   baud_tick  : one-clk enable at OVERSAMPLE x baud rate
//   tx_start   : send request, only looked at while idle
//   tx_data    : word to send, captured when tx_start is accepted
//   serial_out : registered serial line, idle high
//   tx_busy    : frame in progress
//   tx_done    : one-clk pulse after the stop bit completes
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATAWIDTH  = UART_DATAWIDTH,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 tx_start,
  input  logic [DATAWIDTH-1:0] tx_data,
  output logic                 serial_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int TICK_W = cnt_width(OVERSAMPLE);
  localparam int BIT_W  = cnt_width(DATAWIDTH);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATAWIDTH - 1);

  tx_state_t         state_reg, state_next;
  logic [TICK_W-1:0] tick_cnt_reg, tick_cnt_next;
  logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic              serial_reg, serial_next;
  logic              done_reg, done_next;
  logic              bit_end;
  logic              piso_load, piso_shift, piso_lsb;

  tx_piso_reg #(
    .WIDTH(DATAWIDTH)
  ) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load     (piso_load),
    .load_data(tx_data),
    .shift    (piso_shift),
    .lsb      (piso_lsb)
  );

  // Last tick of the current serial bit.
  assign bit_end = baud_tick && (tick_cnt_reg == TICK_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      serial_reg   <= 1'b1;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      serial_reg   <= serial_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    serial_next   = serial_reg;
    done_next     = 1'b0;
    piso_load     = 1'b0;
    piso_shift    = 1'b0;

    // The tick counter only runs inside a frame; acceptance zeroes it so the
    // start bit gets a full OVERSAMPLE ticks regardless of tick phase.
    if (state_reg != IDLE && baud_tick) begin
      tick_cnt_next = bit_end ? '0 : tick_cnt_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        serial_next = 1'b1;
        if (tx_start) begin
          state_next    = START;
          piso_load     = 1'b1;
          tick_cnt_next = '0;
          bit_cnt_next  = '0;
          serial_next   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          // Present data bit 0 and advance the register so its LSB is
          // always the bit that goes out at the next bit boundary.
          state_next  = DATA;
          serial_next = piso_lsb;
          piso_shift  = 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          piso_shift = 1'b1;
          if (bit_cnt_reg == BIT_LAST) begin
            state_next  = STOP;
            serial_next = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            serial_next  = piso_lsb;
          end
        end
      end
      STOP: begin
        serial_next = 1'b1;
        if (bit_end) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next  = IDLE;
        serial_next = 1'b1;
      end
    endcase
  end

  assign serial_out = serial_reg;
  assign tx_busy    = (state_reg != IDLE);
  assign tx_done    = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed bench for uart_tx. Instance dut4 runs OVERSAMPLE=4
// with a tick every clk; instance dut16 runs OVERSAMPLE=16 with a tick every
// third clk and is decoded by a mid-bit sampling receiver model.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick4, start4, ser4, busy4, done4;
  logic [7:0] data4;
  logic       tick16, start16, ser16, busy16, done16;
  logic [7:0] data16;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  uart_tx #(.DATAWIDTH(8), .OVERSAMPLE(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (tick4),
    .tx_start  (start4),
    .tx_data   (data4),
    .serial_out(ser4),
    .tx_busy   (busy4),
    .tx_done   (done4)
  );

  uart_tx #(.DATAWIDTH(8), .OVERSAMPLE(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (tick16),
    .tx_start  (start16),
    .tx_data   (data16),
    .serial_out(ser16),
    .tx_busy   (busy16),
    .tx_done   (done16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  // tick16 is high for every third edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    tick16 = (cyc % 3 == 0);
  endtask

  task automatic start4_frame(input string tag, input logic [7:0] d);
    start4 = 1'b1;
    data4  = d;
    step();
    start4 = 1'b0;
    check({tag, "_acc_ser"}, ser4, 1'b0);
    check({tag, "_acc_busy"}, busy4, 1'b1);
  endtask

  // Called just after the acceptance edge; ends in the tx_done cycle.
  // exp holds the line value of frame bit i in bit i.
  task automatic watch_frame(input string tag, input logic [9:0] exp,
                             input int pulse_cyc, input logic [7:0] pulse_data);
    logic [9:0] obs;
    logic       stable_ok, busy_ok;
    int         done_cnt;
    obs = '0;
    stable_ok = 1'b1;
    busy_ok = 1'b1;
    done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (n % 4 == 0) obs[n/4] = ser4;
      else if (ser4 !== obs[n/4]) stable_ok = 1'b0;
      if (busy4 !== 1'b1) busy_ok = 1'b0;
      if (done4 !== 1'b0) done_cnt++;
      if (pulse_cyc >= 0 && n == pulse_cyc) begin
        start4 = 1'b1;
        data4  = pulse_data;
      end else if (pulse_cyc >= 0 && n == pulse_cyc + 1) begin
        start4 = 1'b0;
      end
      step();
    end
    $display("txn %s frame=%03h", tag, obs);
    check({tag, "_frame"}, obs, exp);
    check({tag, "_stable"}, stable_ok, 1'b1);
    check({tag, "_busy"}, busy_ok, 1'b1);
    check({tag, "_early_done"}, done_cnt, 0);
    check({tag, "_done"}, done4, 1'b1);
    check({tag, "_done_busy"}, busy4, 1'b0);
    check({tag, "_done_ser"}, ser4, 1'b1);
  endtask

  // Send one byte on dut16 and decode it by sampling each bit mid-way.
  task automatic frame16(input string tag, input logic [7:0] d);
    logic [9:0] obs;
    int         n;
    while (cyc % 3 != 0) step();
    start16 = 1'b1;
    data16  = d;
    step();
    start16 = 1'b0;
    obs = '0;
    n = 0;
    while (done16 !== 1'b1 && n < 600) begin
      if (n % 48 == 24 && n / 48 < 10) obs[n/48] = ser16;
      step();
      n++;
    end
    $display("txn %s sent=%02h rx=%02h clks=%0d", tag, d, obs[8:1], n);
    check({tag, "_len"}, n, 480);
    check({tag, "_frame"}, obs, {1'b1, d, 1'b0});
    check({tag, "_rx_data"}, obs[8:1], d);
  endtask

  initial begin
    logic       frozen_ok;
    int         n;
    int         done_cnt;
    logic [7:0] rnd;

    rst = 1'b0;
    tick4 = 1'b1;
    start4 = 1'b0;
    data4 = '0;
    tick16 = 1'b0;
    start16 = 1'b0;
    data16 = '0;

    repeat (3) step();
    check("rst_ser", ser4, 1'b1);
    check("rst_busy", busy4, 1'b0);
    check("rst_done", done4, 1'b0);
    check("rst_ser16", ser16, 1'b1);

    // Start requested in the very first cycle after reset release.
    rst = 1'b1;
    start4_frame("a5", 8'hA5);
    watch_frame("a5", 10'h34A, -1, 8'h00);
    step();
    check("a5_done_pulse", done4, 1'b0);

    // tx_start held high: 00 then FF back to back.
    start4 = 1'b1;
    data4  = 8'h00;
    step();
    check("b2b0_acc_ser", ser4, 1'b0);
    check("b2b0_acc_busy", busy4, 1'b1);
    data4 = 8'hFF;
    watch_frame("b2b0", 10'h200, -1, 8'h00);
    step();
    check("b2b1_acc_ser", ser4, 1'b0);
    check("b2b1_acc_busy", busy4, 1'b1);
    start4 = 1'b0;
    watch_frame("b2b1", 10'h3FE, -1, 8'h00);
    step();

    // Mid-frame start with 3C is ignored.
    start4_frame("ign", 8'h96);
    watch_frame("ign", 10'h32C, 10, 8'h3C);
    step();
    check("ign_done_pulse", done4, 1'b0);
    repeat (8) step();
    check("ign_idle", busy4, 1'b0);

    // Reset during data bit 3 of 5A aborts the frame.
    start4_frame("abort", 8'h5A);
    repeat (17) step();
    rst = 1'b0;
    step();
    check("abort_ser", ser4, 1'b1);
    check("abort_busy", busy4, 1'b0);
    rst = 1'b1;
    done_cnt = 0;
    repeat (50) begin
      step();
      if (done4 !== 1'b0) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    start4_frame("clean5a", 8'h5A);
    watch_frame("clean5a", 10'h2B4, -1, 8'h00);
    step();

    // baud_tick held low freezes the frame during data bit 0 of C3.
    start4_frame("frz", 8'hC3);
    repeat (6) step();
    tick4 = 1'b0;
    check("frz_ser", ser4, 1'b1);
    frozen_ok = 1'b1;
    repeat (20) begin
      step();
      if (ser4 !== 1'b1 || busy4 !== 1'b1 || done4 !== 1'b0) frozen_ok = 1'b0;
    end
    check("frz_hold", frozen_ok, 1'b1);
    tick4 = 1'b1;
    n = 0;
    while (done4 !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("frz_remaining", n, 34);
    step();

    // OVERSAMPLE=16, tick every third clk.
    frame16("os16_5a", 8'h5A);
    frame16("os16_81", 8'h81);
    for (int i = 0; i < 3; i++) begin
      rnd = 8'($urandom_range(0, 255));
      frame16("loop", rnd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
